cmd_seq_chk: RTL and testbench
==============================

# cmd_seq_chk

Synthesizable, table-driven command sequencer and in-range checker for the Segway platform. It replays a programmed list of steps. Each step can send a one-byte command to a UART transmitter (for example 8'h67 "go" or 8'h73 "stop"), wait a programmed number of cycles, and then check a monitored signed value against a [lo, hi] window. Results are accumulated in pass/fail counters. It sits between a UART_tx instance and a monitored datapath signal (e.g. theta_platform, lft_spd) for on-board self-test and bring-up.

## Interface
Parameters:
- NUM_STEPS, 8, depth of step table (2..64)
- DLY_W, 24, width of per-step delay count
- CHK_W, 16, width of monitored signed value and window bounds

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; synchronous, active-high
- step_wr  in  1  write strobe for step table
- step_addr  in  $clog2(NUM_STEPS)  table write address
- step_send  in  1  step sends a command byte
- step_cmd  in  8  command byte
- step_dly  in  DLY_W  post-send delay in cycles
- step_chk  in  1  step performs window check
- step_lo, step_hi  in  CHK_W  signed inclusive window bounds
- step_last  in  1  step terminates sequence
- start  in  1  begin sequence at step 0 (pulse)
- abort  in  1  abandon sequence, return to IDLE
- mon_val  in  CHK_W  signed monitored value
- tx_done  in  1  UART_tx completion pulse
- trmt  out  1  one-cycle transmit request to UART_tx
- tx_data  out  8  command byte, held stable from trmt through tx_done
- busy  out  1  sequence running
- done  out  1  one-cycle pulse at normal completion
- step_idx  out  $clog2(NUM_STEPS)  current step
- pass_cnt, fail_cnt  out  8  saturating check counters
- first_fail  out  $clog2(NUM_STEPS)  index of first failing step
- any_fail  out  1  sticky, at least one check failed

## Operation
- Table: NUM_STEPS register entries. A write occurs on step_wr in IDLE only; step_wr while busy is ignored. Table contents survive rst; the entries are not reset.
- FSM states: IDLE, ISSUE, WAIT_TX, DELAY, CHECK, NEXT.
- IDLE: on start, clear pass_cnt, fail_cnt, any_fail, first_fail, set step_idx=0, busy=1 -> ISSUE.
- ISSUE: if step_send, assert trmt for exactly this cycle, drive tx_data=step_cmd -> WAIT_TX. Else -> DELAY.
- WAIT_TX: hold tx_data; on tx_done -> DELAY.
- DELAY: load counter with step_dly on entry. Leave after exactly step_dly cycles; step_dly=0 means zero cycles spent (direct to CHECK).
- CHECK: if step_chk, sample mon_val, pass iff lo <= mon_val <= hi (signed compare). Pass increments pass_cnt; fail increments fail_cnt, and if any_fail was 0, sets first_fail=step_idx and any_fail=1. Counters saturate at 255. lo > hi always fails.
- NEXT: if step_last or step_idx==NUM_STEPS-1, pulse done, busy=0 -> IDLE. Else step_idx+1 -> ISSUE.
- abort in any non-IDLE state: -> IDLE next cycle, busy=0, no done pulse, counters retain values, trmt never asserted that cycle.
- start while busy: ignored. start and abort together in IDLE: abort wins.
- tx_done outside WAIT_TX: ignored.

## Timing
- Reset values: trmt=0, tx_data=0, busy=0, done=0, step_idx=0, pass_cnt=0, fail_cnt=0, first_fail=0, any_fail=0, state IDLE.
- All outputs registered.
- start at cycle 0 -> busy=1 at cycle 1. Step with send: trmt high at cycle 1 (ISSUE).
- Step without send, dly=0, chk=1: ISSUE, CHECK, NEXT = 3 cycles per step. Add D cycles for dly=D, plus the WAIT_TX residency when sending.
- Check result visible in counters the cycle after CHECK.
- done pulses on the cycle busy falls.

## Test plan
- Reset mid-sequence (step 2 in DELAY) -> next cycle all outputs at reset values; table still readable by rerun giving identical results.
- Single step {send, cmd=8'h67, dly=0, chk=0, last} with UART_tx loopback -> one trmt pulse, tx_data=8'h67 held until tx_done, done 2 cycles after tx_done, pass_cnt=fail_cnt=0.
- Three steps no send, dly=10, windows [-100,100]; mon_val=0, 200, -100 -> pass_cnt=2, fail_cnt=1, first_fail=1, any_fail=1; busy exactly 3*(3+10) cycles.
- Step with dly=0 and lo=hi=16'h0FFF, mon_val=16'h0FFF -> pass; mon_val=16'h0FFE -> fail.
- abort during WAIT_TX of step 1 -> IDLE next cycle, no done, later tx_done ignored, step_wr accepted afterwards.
- NUM_STEPS=4, no last flags, 300 failing re-runs without clearing? No: clearing occurs on start; within one run of 4 fails -> fail_cnt=4, and step_wr during run leaves table unchanged.

Source files
------------

// File: rtl/cmd_seq_chk_if.sv
// UART transmit handshake between the command sequencer and a UART_tx instance.
// The sequencer drives trmt/tx_data; the transmitter answers with a tx_done pulse.
interface cmd_seq_chk_if;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_done;

  modport master (output trmt, output tx_data, input tx_done);
  modport slave  (input trmt, input tx_data, output tx_done);
endinterface

// File: rtl/cmd_seq_chk.sv
// Table-driven command sequencer and in-range checker: replays programmed steps that
// send a UART command, wait, and check a signed monitored value against a window.
module cmd_seq_chk #(
  parameter int NUM_STEPS = 8,
  parameter int DLY_W     = 24,
  parameter int CHK_W     = 16,
  localparam int AW       = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_wr,
  input  logic [AW-1:0]    step_addr,
  input  logic             step_send,
  input  logic [7:0]       step_cmd,
  input  logic [DLY_W-1:0] step_dly,
  input  logic             step_chk,
  input  logic [CHK_W-1:0] step_lo,
  input  logic [CHK_W-1:0] step_hi,
  input  logic             step_last,
  input  logic             start,
  input  logic             abort,
  input  logic [CHK_W-1:0] mon_val,
  cmd_seq_chk_if.master    uart,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    step_idx,
  output logic [7:0]       pass_cnt,
  output logic [7:0]       fail_cnt,
  output logic [AW-1:0]    first_fail,
  output logic             any_fail
);

  localparam logic [AW-1:0]    LAST_IDX = AW'(NUM_STEPS - 1);
  localparam logic [DLY_W-1:0] CNT_ONE  = DLY_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_TX = 3'd2,
    S_DELAY   = 3'd3,
    S_CHECK   = 3'd4,
    S_NEXT    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;

  logic             tbl_send_q [NUM_STEPS];
  logic [7:0]       tbl_cmd_q  [NUM_STEPS];
  logic [DLY_W-1:0] tbl_dly_q  [NUM_STEPS];
  logic             tbl_chk_q  [NUM_STEPS];
  logic [CHK_W-1:0] tbl_lo_q   [NUM_STEPS];
  logic [CHK_W-1:0] tbl_hi_q   [NUM_STEPS];
  logic             tbl_last_q [NUM_STEPS];

  logic       trmt_q, trmt_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] pass_q, pass_d;
  logic [7:0] fail_q, fail_d;
  logic [AW-1:0] ff_q, ff_d;
  logic       af_q, af_d;

  logic start_s;
  logic chk_s;
  logic in_win_s;

  // Step table: no reset so a programmed sequence survives rst; writable only in IDLE.
  always_ff @(posedge clk) begin
    if (step_wr && (state_q == S_IDLE) && (step_addr <= LAST_IDX)) begin
      tbl_send_q[step_addr] <= step_send;
      tbl_cmd_q[step_addr]  <= step_cmd;
      tbl_dly_q[step_addr]  <= step_dly;
      tbl_chk_q[step_addr]  <= step_chk;
      tbl_lo_q[step_addr]   <= step_lo;
      tbl_hi_q[step_addr]   <= step_hi;
      tbl_last_q[step_addr] <= step_last;
    end
  end

  // State, step index and delay counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a zero delay skips DELAY entirely.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_ISSUE;
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE, S_WAIT_TX: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if ((state_q == S_ISSUE) && tbl_send_q[idx_q]) begin
          state_d = S_WAIT_TX;
        end else if ((state_q == S_WAIT_TX) && !uart.tx_done) begin
          state_d = S_WAIT_TX;
        end else if (tbl_dly_q[idx_q] == '0) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_DELAY;
          cnt_d   = tbl_dly_q[idx_q];
        end
      end
      S_DELAY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_ONE) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (abort || tbl_last_q[idx_q] || (idx_q == LAST_IDX)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ISSUE;
          idx_d   = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign start_s  = (state_q == S_IDLE) && start && !abort;
  assign chk_s    = (state_q == S_CHECK) && !abort && tbl_chk_q[idx_q];
  assign in_win_s = ($signed(mon_val) >= $signed(tbl_lo_q[idx_q])) &&
                    ($signed(mon_val) <= $signed(tbl_hi_q[idx_q]));

  // Output next values, derived from the upcoming state so every output is a flop.
  always_comb begin
    trmt_d    = 1'b0;
    tx_data_d = tx_data_q;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_q == S_NEXT) && (state_d == S_IDLE) && !abort;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ff_d      = ff_q;
    af_d      = af_q;
    if (state_d == S_ISSUE) begin
      trmt_d = tbl_send_q[idx_d];
    end else begin
      trmt_d = 1'b0;
    end
    if (trmt_d) begin
      tx_data_d = tbl_cmd_q[idx_d];
    end else begin
      tx_data_d = tx_data_q;
    end
    if (start_s) begin
      pass_d = 8'd0;
      fail_d = 8'd0;
      ff_d   = '0;
      af_d   = 1'b0;
    end else if (chk_s && in_win_s) begin
      pass_d = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
    end else if (chk_s) begin
      fail_d = (fail_q == 8'hFF) ? fail_q : fail_q + 8'd1;
      ff_d   = af_q ? ff_q : idx_q;
      af_d   = 1'b1;
    end else begin
      pass_d = pass_q;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      trmt_q    <= 1'b0;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 8'd0;
      fail_q    <= 8'd0;
      ff_q      <= '0;
      af_q      <= 1'b0;
    end else begin
      trmt_q    <= trmt_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      ff_q      <= ff_d;
      af_q      <= af_d;
    end
  end

  assign uart.trmt    = trmt_q;
  assign uart.tx_data = tx_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign step_idx     = idx_q;
  assign pass_cnt     = pass_q;
  assign fail_cnt     = fail_q;
  assign first_fail   = ff_q;
  assign any_fail     = af_q;

endmodule

// File: tb/tb_cmd_seq_chk.sv
// Self-checking bench for cmd_seq_chk: a timeline model derived from the step rules
// is compared cycle by cycle, plus directed abort/reset scenarios with literal values.
module tb_cmd_seq_chk;
  localparam int NS = 4;
  localparam logic [15:0] JUNK = 16'h8000;

  logic        clk = 1'b0;
  logic        rst, step_wr, step_send, step_chk, step_last, start, abort;
  logic [1:0]  step_addr;
  logic [7:0]  step_cmd;
  logic [23:0] step_dly;
  logic [15:0] step_lo, step_hi, mon_val;
  logic        busy, done, any_fail;
  logic [1:0]  step_idx, first_fail;
  logic [7:0]  pass_cnt, fail_cnt;

  cmd_seq_chk_if u_if();

  cmd_seq_chk #(.NUM_STEPS(NS), .DLY_W(24), .CHK_W(16)) dut (
    .clk(clk), .rst(rst), .step_wr(step_wr), .step_addr(step_addr),
    .step_send(step_send), .step_cmd(step_cmd), .step_dly(step_dly),
    .step_chk(step_chk), .step_lo(step_lo), .step_hi(step_hi),
    .step_last(step_last), .start(start), .abort(abort), .mon_val(mon_val),
    .uart(u_if), .busy(busy), .done(done), .step_idx(step_idx),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail(first_fail),
    .any_fail(any_fail)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       trmt;
    logic [7:0] tx;
    logic       busy;
    logic       done;
    logic [1:0] idx;
    logic [7:0] pc;
    logic [7:0] fc;
    logic [1:0] ff;
    logic       af;
    logic       txd;
    logic [15:0] mon;
  } ent_t;

  ent_t q[$];

  logic        m_send [NS];
  logic [7:0]  m_cmd  [NS];
  int          m_dly  [NS];
  logic        m_chk  [NS];
  logic [15:0] m_lo   [NS];
  logic [15:0] m_hi   [NS];
  logic [15:0] m_mon  [NS];
  logic        m_last [NS];

  logic [7:0] e_tx, e_pc, e_fc;
  logic [1:0] e_idx, e_ff;
  logic       e_af;

  int n_chk = 0;
  int n_err = 0;
  int busy_n, done_at;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic put(input logic t, input logic b, input logic d, input logic txd,
                     input logic [15:0] mon);
    ent_t e;
    e.trmt = t;  e.tx = e_tx; e.busy = b; e.done = d; e.idx = e_idx;
    e.pc = e_pc; e.fc = e_fc; e.ff = e_ff; e.af = e_af; e.txd = txd; e.mon = mon;
    q.push_back(e);
  endtask

  // Expected per-cycle timeline of one run: ISSUE, UART wait, delay, CHECK, NEXT per step.
  task automatic build_run(input int lat);
    logic ok;
    bit   fin;
    q.delete();
    e_pc = 8'd0; e_fc = 8'd0; e_ff = 2'd0; e_af = 1'b0;
    fin = 1'b0;
    for (int s = 0; s < NS && !fin; s++) begin
      e_idx = 2'(s);
      if (m_send[s]) e_tx = m_cmd[s];
      put(m_send[s], 1'b1, 1'b0, 1'b0, JUNK);
      if (m_send[s])
        for (int k = 1; k <= lat; k++) put(1'b0, 1'b1, 1'b0, k == lat, JUNK);
      for (int k = 0; k < m_dly[s]; k++) put(1'b0, 1'b1, 1'b0, 1'b0, JUNK);
      put(1'b0, 1'b1, 1'b0, 1'b0, m_mon[s]);
      if (m_chk[s]) begin
        ok = ($signed(m_mon[s]) >= $signed(m_lo[s])) && ($signed(m_mon[s]) <= $signed(m_hi[s]));
        if (ok) begin
          if (e_pc != 8'd255) e_pc = e_pc + 8'd1;
        end else begin
          if (e_fc != 8'd255) e_fc = e_fc + 8'd1;
          if (!e_af) begin e_af = 1'b1; e_ff = 2'(s); end
        end
      end
      put(1'b0, 1'b1, 1'b0, 1'b0, JUNK);
      if (m_last[s] || s == NS - 1) fin = 1'b1;
    end
    put(1'b0, 1'b0, 1'b1, 1'b0, JUNK);
    put(1'b0, 1'b0, 1'b0, 1'b0, JUNK);
    put(1'b0, 1'b0, 1'b0, 1'b0, JUNK);
  endtask

  task automatic prog(input int a, input logic snd, input logic [7:0] cmd, input int dly,
                      input logic ck, input logic [15:0] lo, input logic [15:0] hi,
                      input logic lst, input logic [15:0] mon);
    m_send[a] = snd; m_cmd[a] = cmd; m_dly[a] = dly; m_chk[a] = ck;
    m_lo[a] = lo; m_hi[a] = hi; m_last[a] = lst; m_mon[a] = mon;
    step_addr = 2'(a); step_send = snd; step_cmd = cmd; step_dly = 24'(dly);
    step_chk = ck; step_lo = lo; step_hi = hi; step_last = lst; step_wr = 1'b1;
    @(posedge clk); #1;
    step_wr = 1'b0;
  endtask

  // Start a run and compare every output on every cycle against the timeline.
  task automatic run(input int lat, input bit wr_mid);
    build_run(lat);
    busy_n = 0; done_at = -1;
    start = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      chk("trmt", u_if.trmt, q[i].trmt);
      chk("tx_data", u_if.tx_data, q[i].tx);
      chk("busy", busy, q[i].busy);
      chk("done", done, q[i].done);
      chk("step_idx", step_idx, q[i].idx);
      chk("pass_cnt", pass_cnt, q[i].pc);
      chk("fail_cnt", fail_cnt, q[i].fc);
      chk("first_fail", first_fail, q[i].ff);
      chk("any_fail", any_fail, q[i].af);
      if (busy) busy_n++;
      if (done && done_at < 0) done_at = i + 1;
      u_if.tx_done = q[i].txd;
      mon_val = q[i].mon;
      if (wr_mid && i == 2) begin
        step_wr = 1'b1; step_addr = 2'd0; step_send = 1'b0; step_chk = 1'b0;
        step_dly = 24'd0; step_last = 1'b1;
      end else begin
        step_wr = 1'b0;
      end
    end
    u_if.tx_done = 1'b0;
    step_wr = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".trmt"}, u_if.trmt, 1'b0);
    chk({tag, ".tx_data"}, u_if.tx_data, 8'h00);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".step_idx"}, step_idx, 2'd0);
    chk({tag, ".pass_cnt"}, pass_cnt, 8'd0);
    chk({tag, ".fail_cnt"}, fail_cnt, 8'd0);
    chk({tag, ".first_fail"}, first_fail, 2'd0);
    chk({tag, ".any_fail"}, any_fail, 1'b0);
  endtask

  initial begin
    rst = 1'b1; step_wr = 1'b0; start = 1'b0; abort = 1'b0; mon_val = JUNK;
    step_addr = 2'd0; step_send = 1'b0; step_cmd = 8'h00; step_dly = 24'd0;
    step_chk = 1'b0; step_lo = 16'h0000; step_hi = 16'h0000; step_last = 1'b0;
    u_if.tx_done = 1'b0;
    e_tx = 8'h00; e_pc = 8'd0; e_fc = 8'd0; e_idx = 2'd0; e_ff = 2'd0; e_af = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_vals("reset");
    for (int a = 0; a < NS; a++) prog(a, 1'b0, 8'h00, 0, 1'b0, 16'h0000, 16'h0000, 1'b1, JUNK);

    // Single send step with a 5-cycle UART loopback.
    prog(0, 1'b1, 8'h67, 0, 1'b0, 16'h0000, 16'h0000, 1'b1, JUNK);
    run(5, 1'b0);
    chk("t1.busy_cycles", busy_n, 8);
    chk("t1.done_cycle", done_at, 9);
    chk("t1.pass_cnt", pass_cnt, 8'd0);
    chk("t1.fail_cnt", fail_cnt, 8'd0);

    // Three delayed checks against [-100,100] with values 0, 200, -100.
    prog(0, 1'b0, 8'h00, 10, 1'b1, 16'hFF9C, 16'd100, 1'b0, 16'd0);
    prog(1, 1'b0, 8'h00, 10, 1'b1, 16'hFF9C, 16'd100, 1'b0, 16'd200);
    prog(2, 1'b0, 8'h00, 10, 1'b1, 16'hFF9C, 16'd100, 1'b1, 16'hFF9C);
    run(1, 1'b0);
    chk("t2.busy_cycles", busy_n, 39);
    chk("t2.done_cycle", done_at, 40);
    chk("t2.pass_cnt", pass_cnt, 8'd2);
    chk("t2.fail_cnt", fail_cnt, 8'd1);
    chk("t2.first_fail", first_fail, 2'd1);
    chk("t2.any_fail", any_fail, 1'b1);

    // Reset while step 2 is in DELAY, then rerun the untouched table.
    start = 1'b1; mon_val = 16'd0;
    for (int c = 1; c <= 31; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 29) begin
        chk("t6.idx_before", step_idx, 2'd2);
        chk("t6.busy_before", busy, 1'b1);
      end
      if (c == 31) chk_reset_vals("t6.after_rst");
      rst = (c == 30);
    end
    e_tx = 8'h00;
    run(1, 1'b0);
    chk("t6.rerun_pass", pass_cnt, 8'd2);
    chk("t6.rerun_fail", fail_cnt, 8'd1);

    // Degenerate window lo=hi=0x0FFF: exact match passes, one below fails.
    prog(0, 1'b0, 8'h00, 0, 1'b1, 16'h0FFF, 16'h0FFF, 1'b0, 16'h0FFF);
    prog(1, 1'b0, 8'h00, 0, 1'b1, 16'h0FFF, 16'h0FFF, 1'b1, 16'h0FFE);
    run(1, 1'b0);
    chk("t3.done_cycle", done_at, 7);
    chk("t3.pass_cnt", pass_cnt, 8'd1);
    chk("t3.fail_cnt", fail_cnt, 8'd1);
    chk("t3.first_fail", first_fail, 2'd1);

    // Four failing steps, no last flag, with a table write attempted mid-run.
    prog(0, 1'b1, 8'h73, 3, 1'b1, 16'd5, 16'hFFFB, 1'b0, 16'd0);
    prog(1, 1'b0, 8'h00, 0, 1'b1, 16'd10, 16'd10, 1'b0, 16'd0);
    prog(2, 1'b0, 8'h00, 1, 1'b1, 16'hFF9C, 16'hFFFF, 1'b0, 16'd0);
    prog(3, 1'b0, 8'h00, 0, 1'b1, 16'd1, 16'd100, 1'b0, 16'hFFFF);
    run(3, 1'b1);
    chk("t4.busy_cycles", busy_n, 19);
    chk("t4.done_cycle", done_at, 20);
    chk("t4.fail_cnt", fail_cnt, 8'd4);
    chk("t4.first_fail", first_fail, 2'd0);
    chk("t4.step_idx", step_idx, 2'd3);
    run(3, 1'b0);
    chk("t4.rerun_fail", fail_cnt, 8'd4);
    chk("t4.rerun_done", done_at, 20);

    // Abort during WAIT_TX of step 1; late tx_done and start+abort both ignored.
    prog(0, 1'b0, 8'h00, 0, 1'b1, 16'hFFF6, 16'd10, 1'b0, 16'd0);
    prog(1, 1'b1, 8'h73, 2, 1'b1, 16'hFFF6, 16'd10, 1'b1, 16'd0);
    start = 1'b1; mon_val = 16'd0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 3) chk("t5.pass_step0", pass_cnt, 8'd1);
      if (c == 4) begin
        chk("t5.trmt", u_if.trmt, 1'b1);
        chk("t5.tx_data", u_if.tx_data, 8'h73);
        chk("t5.idx", step_idx, 2'd1);
      end
      if (c == 5) chk("t5.wait_busy", busy, 1'b1);
      if (c == 7) begin
        chk("t5.abort_done", done, 1'b0);
        chk("t5.abort_pass", pass_cnt, 8'd1);
        chk("t5.abort_idx", step_idx, 2'd1);
      end
      if (c >= 7) begin
        chk("t5.abort_busy", busy, 1'b0);
        chk("t5.abort_trmt", u_if.trmt, 1'b0);
      end
      abort = (c == 6);
      u_if.tx_done = (c == 8);
    end
    u_if.tx_done = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("t5.start_abort_busy", busy, 1'b0);
    chk("t5.start_abort_pass", pass_cnt, 8'd1);
    e_tx = 8'h73;
    prog(0, 1'b1, 8'hA5, 0, 1'b0, 16'h0000, 16'h0000, 1'b1, JUNK);
    run(2, 1'b0);
    chk("t5.rewrite_done", done_at, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
